// File: rtl/hsid_fifo_reader.sv
// hsid_fifo_reader: drains word_count words from hsid_fifo into a 2-entry valid/ready output buffer
module hsid_fifo_reader #(
  parameter int WORD_WIDTH = 8,
  parameter int COUNT_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] word_count,
  output logic                   busy,
  output logic                   done,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [WORD_WIDTH-1:0]  fifo_data,
  output logic                   m_valid,
  output logic [WORD_WIDTH-1:0]  m_data,
  output logic                   m_last,
  input  logic                   m_ready
);
  typedef enum logic [1:0] {IDLE, READ, FINISH} state_t;
  state_t state;
  logic [COUNT_WIDTH-1:0] rem_rd, rem_out;
  logic [1:0] occ;
  logic inflight, pop, push, shift, head_wr, tail_wr, in_last, tail_last;
  logic [WORD_WIDTH-1:0] tail_data;
  always_comb begin
    m_valid = occ != 2'd0;
    pop = m_valid && m_ready;
    push = inflight;
    fifo_rd_en = rst_n && !clear && state == READ && !fifo_empty && rem_rd != '0 &&
                 ({1'b0, occ} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
    shift = occ == 2'd2 && pop;
    head_wr = push && (occ == 2'd0 || (occ == 2'd1 && pop));
    tail_wr = push && ((occ == 2'd1 && !pop) || shift);
    in_last = rem_out == COUNT_WIDTH'(1);
    busy = state != IDLE;
    done = state == FINISH;
  end
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state <= IDLE;
      rem_rd <= '0;
      rem_out <= '0;
      occ <= 2'd0;
      inflight <= 1'b0;
      m_data <= '0;
      m_last <= 1'b0;
      tail_data <= '0;
      tail_last <= 1'b0;
    end else begin
      state <= state == IDLE ? (start ? (word_count == '0 ? FINISH : READ) : IDLE) :
               state == READ ? (pop && m_last ? FINISH : READ) : IDLE;
      inflight <= fifo_rd_en;
      occ <= occ + 2'(push) - 2'(pop);
      if (state == IDLE && start) begin
        rem_rd <= word_count;
        rem_out <= word_count;
      end else begin
        if (fifo_rd_en) rem_rd <= rem_rd - COUNT_WIDTH'(1);
        if (push) rem_out <= rem_out - COUNT_WIDTH'(1);
      end
      if (head_wr) begin
        m_data <= fifo_data;
        m_last <= in_last;
      end else if (shift) begin
        m_data <= tail_data;
        m_last <= tail_last;
      end else if (pop) m_last <= 1'b0;
      if (tail_wr) begin
        tail_data <= fifo_data;
        tail_last <= in_last;
      end
    end
  end
endmodule

// File: doc/hsid_fifo_reader.md
# hsid_fifo_reader

Drain-side controller for `hsid_fifo`. On a `start` command it pulls exactly `word_count` words out of the FIFO by driving its `rd_en` and capturing its registered `data_out` one cycle later. It presents the words downstream as a valid/ready stream with `m_last` on the final word. It sits between a band FIFO and the distance datapath, and absorbs FIFO read latency and downstream back-pressure with a 2-entry output buffer.

## Interface
- `WORD_WIDTH`, default `HSID_WORD_WIDTH`: stream and FIFO word width.
- `COUNT_WIDTH`, default 10: width of `word_count`; up to 2^COUNT_WIDTH−1 words per transfer.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `clear`  in  1  synchronous abort; same effect as reset.
- `start`  in  1  begin transfer; sampled only in IDLE.
- `word_count`  in  COUNT_WIDTH  number of words; latched on accepted `start`.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse when the transfer completes.
- `fifo_empty`  in  1  from FIFO `empty`.
- `fifo_rd_en`  out  1  to FIFO `rd_en`.
- `fifo_data`  in  WORD_WIDTH  from FIFO `data_out`; valid the cycle after a `fifo_rd_en` cycle.
- `m_valid`  out  1  output word valid.
- `m_data`  out  WORD_WIDTH  output word.
- `m_last`  out  1  qualifies the final word of the transfer.
- `m_ready`  in  1  downstream accept.

## Operation
- **States:** IDLE, READ, FINISH.
  - IDLE → READ on `start`, latching `word_count` into `remaining_rd` and `remaining_out`.
  - IDLE → FINISH if the latched count is 0.
  - READ → FINISH on the handshake (`m_valid && m_ready`) of the word with `m_last`.
  - FINISH → IDLE unconditionally after 1 cycle; `done` = 1 in FINISH.
- **Read issue:** `fifo_rd_en` = READ && `!fifo_empty` && `remaining_rd` != 0 && (occ + inflight − pop) < 2.
  - occ: output buffer occupancy, 0..2.
  - inflight: registered copy of last cycle's `fifo_rd_en`.
  - pop: `m_valid && m_ready`.
  - Combinational path from `m_ready` to `fifo_rd_en` is permitted.
- Each issued read decrements `remaining_rd`. When `inflight` = 1, `fifo_data` is written into the buffer that cycle.
- **Output buffer:** 2-entry FIFO, in-order, with a registered head.
  - `m_valid` = occ != 0.
  - `m_data`/`m_last` hold stable while `m_valid && !m_ready`.
  - A push and a pop in the same cycle leave occ unchanged.
- **`m_last`:** set on the buffered word whose capture brings captured-word count to the latched total. Tracked with `remaining_out`, which decrements on each capture; the word captured when `remaining_out` == 1 carries last.
- **`start` handling:** ignored while `busy`, including in FINISH.
- **Reset / `clear`** (takes priority over everything): state IDLE, occ 0, inflight 0, counters 0.
  - An in-flight FIFO word arriving the cycle after `clear` is discarded.
  - Owners must clear the FIFO in the same cycle.
- **Reset values:** `busy` 0, `done` 0, `fifo_rd_en` 0, `m_valid` 0, `m_last` 0, `m_data` 0.
- **Width rules:** counters are COUNT_WIDTH bits and never wrap. `fifo_rd_en` is gated at `remaining_rd` == 0, and pushes only happen for issued reads.

## Timing
- `start` sampled at edge E0. First `fifo_rd_en` in cycle E0+1 if FIFO non-empty. First `m_valid` in cycle E0+3 (read edge, capture edge).
- Sustained throughput: 1 word/cycle with `m_ready` held high and FIFO non-empty.
- Back-pressure: at most 2 reads are outstanding-plus-buffered. No word is ever dropped or duplicated.
- FIFO empty mid-transfer: the reader stalls with `fifo_rd_en` = 0 and resumes the cycle `fifo_empty` falls.
- `done` rises the cycle after the last handshake and is high for exactly 1 cycle. `busy` falls with `done`.
- `word_count` = 0: `busy` 1 for 1 cycle (FINISH), `done` pulses at E0+1, no FIFO reads.

## Test plan
- FIFO preloaded with 0x11..0x15, `word_count` 5, `m_ready` 1 → 5 consecutive `fifo_rd_en` cycles starting E0+1; `m_data` 0x11..0x15 on consecutive cycles from E0+3; `m_last` only with 0x15; `done` pulse 1 cycle later.
- Same preload, `m_ready` toggled 1,0,0,1,0,1… → same data order with no loss or repeat; `m_data` stable while stalled; reads outstanding-plus-buffered never exceed 2.
- `word_count` 4, FIFO holds 2 words, 2 more written 6 cycles later → reader stalls with `fifo_rd_en` 0 while empty, then delivers all 4 in order with `m_last` on the 4th.
- `word_count` 0 → `done` at E0+1; `fifo_rd_en` never asserted; `m_valid` never asserted.
- `clear` asserted the cycle after the 2nd `fifo_rd_en` of an 8-word transfer → next cycle IDLE with `m_valid` 0 and `busy` 0; the in-flight word is not emitted; a new `start` with 3 words runs correctly.
- `start` pulsed during an active transfer, and `rst_n` low mid-transfer → the extra `start` is ignored; after reset all outputs are 0 and state is IDLE.
